// File: rtl/fpu_addsub_sched.sv
// fpu_addsub_sched
//   Shares one fixed-latency pipelined FP32 add/sub unit among NUM_REQ
//   requesters. A round-robin arbiter picks at most one requester per cycle
//   and drives its operands to the unit. The requester ID travels alongside
//   the operation in a LAT-deep tag pipe. When the result leaves the unit, it
//   is registered and steered back to its requester with a one-hot strobe.
//   The scheduler never looks at operand or result data.
//
// Parameters
//   NUM_REQ : number of requesters (2..8)
//   LAT     : latency of the add/sub unit in enabled cycles (>= 1)
//   TAG_W   : requester-ID width, derived from NUM_REQ
//
// Ports
//   clk, rst              : rising-edge clock, synchronous active-high reset
//   en                    : global advance; 0 freezes arbiter, tag pipe and outputs
//   req_valid/req_ready   : per-requester handshake (see below)
//   req_a/req_b/req_sub   : per-requester operands, 32-bit slice i = requester i
//   fpu_a/fpu_b/fpu_sub   : operands of the granted requester, or 0 for a bubble
//   fpu_ce                : unit pipeline enable (follows en)
//   fpu_res               : unit result, valid LAT enabled cycles after issue
//   rsp_valid/rsp_data    : one-hot result strobe plus shared result bus
//   busy                  : at least one operation is in the tag pipe
//
// Optional build macro FPU_SCHED_PERF_EN
//   When defined, adds perf_issue[15:0] and perf_stall[15:0]. Both are
//   saturating counters.
//
// Handshake: a transfer from requester i happens on a rising edge where
//   req_valid[i] & req_ready[i] = 1. req_ready is combinational and is either
//   one-hot or zero. It is zero while rst=1 or en=0. The response path has no
//   backpressure: a requester must accept rsp_valid in the cycle it is asserted.

module fpu_addsub_sched #(
  parameter int NUM_REQ = 4,
  parameter int LAT     = 3,
  localparam int TAG_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]    req_sub,
  output logic [31:0]           fpu_a,
  output logic [31:0]           fpu_b,
  output logic                  fpu_sub,
  output logic                  fpu_ce,
  input  logic [31:0]           fpu_res,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [31:0]           rsp_data,
  output logic                  busy
`ifdef FPU_SCHED_PERF_EN
  ,
  output logic [15:0]           perf_issue,
  output logic [15:0]           perf_stall
`endif
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [TAG_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [LAT-1:0]     pv_q, pv_d;            // tag-pipe valid bits
  logic [TAG_W-1:0]   ptag_q [LAT];          // tag-pipe requester IDs
  logic [TAG_W-1:0]   ptag_d [LAT];
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_data_q, rsp_data_d;

  logic               grant_any;
  logic [TAG_W-1:0]   grant_idx;

  // ---------------------------------------------------------------------------
  // Round-robin arbitration. The search starts at rr_ptr and walks forward
  // modulo NUM_REQ. The first valid requester found wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    int cand;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    if (en && !rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = (int'(rr_ptr_q) + k) % NUM_REQ;
        if (!grant_any && req_valid[cand]) begin
          grant_any = 1'b1;
          grant_idx = TAG_W'(cand);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    fpu_a     = '0;
    fpu_b     = '0;
    fpu_sub   = 1'b0;
    if (grant_any) begin
      req_ready[grant_idx] = 1'b1;
      fpu_a                = req_a[32*grant_idx +: 32];
      fpu_b                = req_b[32*grant_idx +: 32];
      fpu_sub              = req_sub[grant_idx];
    end
  end

  assign fpu_ce = en;

  // ---------------------------------------------------------------------------
  // Next-state logic. grant_any already implies en=1, so the pointer update
  // does not need its own en qualifier.
  // ---------------------------------------------------------------------------
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    pv_d        = pv_q;
    ptag_d      = ptag_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;

    if (grant_any) begin
      rr_ptr_d = (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end

    if (en) begin
      pv_d[0]   = grant_any;
      ptag_d[0] = grant_idx;
      for (int k = 1; k < LAT; k++) begin
        pv_d[k]   = pv_q[k-1];
        ptag_d[k] = ptag_q[k-1];
      end

      // The last tag stage lines up with the cycle in which fpu_res carries
      // this operation's result. The data bus holds its value across bubbles.
      rsp_valid_d = '0;
      if (pv_q[LAT-1]) begin
        rsp_valid_d[ptag_q[LAT-1]] = 1'b1;
        rsp_data_d                 = fpu_res;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      pv_q        <= '0;
      for (int k = 0; k < LAT; k++) ptag_q[k] <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      pv_q        <= pv_d;
      ptag_q      <= ptag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = |pv_q;

`ifdef FPU_SCHED_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters. stall counts every waiting requester in every
  // enabled cycle, so with k valid requesters and one grant it adds k-1.
  // ---------------------------------------------------------------------------
  logic [15:0] perf_issue_q, perf_issue_d;
  logic [15:0] perf_stall_q, perf_stall_d;

  always_comb begin
    logic [4:0]  n_valid;
    logic [4:0]  n_wait;
    logic [16:0] issue_sum;
    logic [16:0] stall_sum;
    n_valid = '0;
    for (int k = 0; k < NUM_REQ; k++) n_valid = n_valid + 5'(req_valid[k]);
    n_wait    = n_valid - 5'(grant_any);
    issue_sum = {1'b0, perf_issue_q} + 17'(grant_any);
    stall_sum = {1'b0, perf_stall_q} + 17'(n_wait);
    perf_issue_d = perf_issue_q;
    perf_stall_d = perf_stall_q;
    if (en) begin
      perf_issue_d = issue_sum[16] ? 16'hFFFF : issue_sum[15:0];
      perf_stall_d = stall_sum[16] ? 16'hFFFF : stall_sum[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issue_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_issue_q <= perf_issue_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_issue = perf_issue_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: doc/fpu_addsub_sched.md
Name: fpu_addsub_sched

Overview:
- Time-multiplexes one fixed-latency pipelined FP32 add/sub unit (unpack, special-case, align, add, normalize/round) among NUM_REQ requesters, e.g. the butterfly lanes of the 8-point FFT.
- Selects one requester per cycle by round-robin and drives the operands to the unit.
- Carries a requester tag through a shift register matched to the unit's latency, then routes each result back to its requester.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LAT, 3, add/sub unit latency in enabled cycles (>=1).
- TAG_W, $clog2(NUM_REQ), requester-ID width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global advance; 0 freezes scheduler and unit pipeline.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_ready  out  NUM_REQ  one-hot grant; transfer when req_valid[i]&req_ready[i].
- req_a  in  32*NUM_REQ  operand A, slice i = requester i.
- req_b  in  32*NUM_REQ  operand B.
- req_sub  in  NUM_REQ  1 = A-B, 0 = A+B.
- fpu_a  out  32  operand A to unit.
- fpu_b  out  32  operand B to unit.
- fpu_sub  out  1  subtract select to unit.
- fpu_ce  out  1  unit pipeline clock enable (= en).
- fpu_res  in  32  unit result, valid LAT enabled cycles after issue.
- rsp_valid  out  NUM_REQ  one-hot result strobe.
- rsp_data  out  32  result (shared bus).
- busy  out  1  any operation in flight.

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - rr_ptr=0, all tag-pipe valid bits=0.
  - rsp_valid=0, rsp_data=0, busy=0.
  - req_ready is combinational and forced 0 while rst=1.
- Arbitration (combinational):
  - When en=1 and rst=0: grant goes to the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready is one-hot or zero.
  - When en=0, req_ready=0.
- Issue:
  - fpu_a/fpu_b/fpu_sub mux the granted slice.
  - With no grant they hold 0 (bubble; the unit result is ignored).
- rr_ptr update: on a grant to i, rr_ptr <= (i+1) mod NUM_REQ (wraps NUM_REQ-1 -> 0). Without a grant it holds.
- Tag pipe:
  - LAT stages of {valid, tag}.
  - Stage 0 loads {grant_any, grant_idx}; stage k loads stage k-1.
  - All stages advance only when en=1; en=0 freezes all stages and outputs.
- Response:
  - Registered; updates only when en=1.
  - rsp_valid <= onehot(tag_LAT-1) if valid_LAT-1, else 0.
  - rsp_data <= fpu_res when valid_LAT-1, else holds its previous value.
- Latency: issue edge to rsp_valid = LAT+1 enabled cycles.
- Throughput: 1 op/cycle. No response backpressure; requesters must accept rsp_valid.
- busy = OR of tag-pipe valid bits.
- Boundary conditions:
  - All requesters valid: strict rotation, each gets one grant per NUM_REQ cycles.
  - Single requester valid: granted every cycle.
  - en deasserted mid-flight: no op is lost or duplicated; ordering is preserved.
  - rst mid-flight: in-flight ops are discarded with no rsp_valid for them. The first cycle after reset grants from requester 0.
  - req_valid dropped before grant: no effect, nothing issued.
- Results, including NaN, Inf and signed zero, pass through unmodified; the scheduler never inspects data.

Optional Feature:
- Macro: FPU_SCHED_PERF_EN.
- When defined, adds two outputs, perf_issue[15:0] and perf_stall[15:0]:
  - perf_issue counts enabled cycles with a grant.
  - perf_stall counts enabled cycles where req_valid!=0 but the requester was not granted, i.e. each waiting-requester cycle counts (popcount(req_valid)-grant_any).
  - Both counters saturate at 16'hFFFF and reset to 0 on rst.
- When undefined, the ports and logic are absent and the block is otherwise identical.

Test Plan:
- Reset then req_valid=4'b0001, a=3F800000, b=40000000, sub=0, LAT=3 -> req_ready=0001 on cycle 0, rsp_valid=0001 four cycles later, rsp_data equals the model's 40400000 from fpu_res.
- req_valid=1111 held for 8 cycles -> grant order 0,1,2,3,0,1,2,3; responses return in the same order 4 cycles after each grant.
- req_valid=1010 after a grant to 3 (rr_ptr wraps to 0) -> next grant 1, then 3, then 1.
- Issue to requesters 0 and 1 on consecutive cycles, then en=0 for 5 cycles, then en=1 -> no rsp_valid during the stall; responses 0,1 appear on the 2nd and 3rd re-enabled edges; busy=1 throughout the stall.
- Issue 3 ops, assert rst 1 cycle at the edge after the third issue -> no rsp_valid ever for those ops; busy=0; the next grant with req_valid=1111 goes to 0.
- With FPU_SCHED_PERF_EN: req_valid=1111 for 10 cycles -> perf_issue=10, perf_stall=30; force 70000 issue cycles -> perf_issue=FFFF.
